// File: rtl/dff_1.sv
// rtl/dff_1.sv - rising-edge D flip-flop with asynchronous active-high reset
module dff_1 #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next state is simply the sampled input; no enable or set path.
    always_comb begin
        q_d = d;
    end

    // Single storage stage; reset branch first so an edge coinciding with reset release is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    // Output comes straight from the flop, never from d.
    assign q = q_q;

endmodule

// File: tb/tb_dff_1.sv
// tb/tb_dff_1.sv - directed self-checking bench for dff_1, its 4-stage chain and an 8-bit instance
module tb_dff_1;

    logic       clk;
    logic       rst;
    logic       d;
    logic       q;
    logic       chain_d;
    logic [3:0] stage;
    logic [7:0] wd;
    logic [7:0] wq;

    int errors;
    int checks;

    dff_1 u_dut (
        .d   (d),
        .clk (clk),
        .rst (rst),
        .q   (q)
    );

    dff_1 u_s0 (chain_d,  clk, rst, stage[0]);
    dff_1 u_s1 (stage[0], clk, rst, stage[1]);
    dff_1 u_s2 (stage[1], clk, rst, stage[2]);
    dff_1 u_s3 (stage[2], clk, rst, stage[3]);

    dff_1 #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_wide (
        .d   (wd),
        .clk (clk),
        .rst (rst),
        .q   (wq)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        d       = 1'b0;
        chain_d = 1'b0;
        wd      = 8'h3C;

        // Reset state while rst held high
        #5;
        check("reset_q", {7'd0, q}, 8'h00);
        check("reset_chain", {4'd0, stage}, 8'h00);
        check("reset_wide", wq, 8'hA5);

        // Release reset exactly on the rising edge at t=10; that edge must be ignored
        d       = 1'b1;
        chain_d = 1'b1;
        @(posedge clk);
        #0 rst = 1'b0;
        #1;
        check("deassert_edge_q", {7'd0, q}, 8'h00);
        check("deassert_edge_wide", wq, 8'hA5);
        check("deassert_edge_chain", {4'd0, stage}, 8'h00);

        // Chain: input 1 for one edge then 0; output pulses only after the 4th edge
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("chain_out_edge%0d", k), {7'd0, stage[3]}, (k == 4) ? 8'h01 : 8'h00);
            if (k == 1) begin
                check("first_capture_q", {7'd0, q}, 8'h01);
                check("first_capture_wide", wq, 8'h3C);
                chain_d = 1'b0;
            end
        end

        // Capture: d changes mid-cycle must not reach q until the next edge
        d = 1'b0;
        @(posedge clk);
        #1;
        check("capture_zero", {7'd0, q}, 8'h00);
        @(negedge clk);
        d = 1'b1;
        #1;
        check("midcycle_hold0", {7'd0, q}, 8'h00);
        @(posedge clk);
        #1;
        check("capture_one", {7'd0, q}, 8'h01);
        @(negedge clk);
        d = 1'b0;
        #1;
        check("midcycle_hold1", {7'd0, q}, 8'h01);
        @(posedge clk);
        #1;
        check("capture_back0", {7'd0, q}, 8'h00);

        // Load 1,0,1 into the chain while q is brought back to 1
        d       = 1'b1;
        wd      = 8'h5A;
        chain_d = 1'b1;
        @(posedge clk);
        #1;
        chain_d = 1'b0;
        @(posedge clk);
        #1;
        chain_d = 1'b1;
        @(posedge clk);
        #1;
        check("chain_pattern", {4'd0, stage}, 8'h05);
        check("q_before_reset", {7'd0, q}, 8'h01);
        check("wide_before_reset", wq, 8'h5A);

        // Asynchronous reset mid-cycle clears everything before the next edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_q", {7'd0, q}, 8'h00);
        check("async_reset_chain", {4'd0, stage}, 8'h00);
        check("async_reset_wide", wq, 8'hA5);

        // Held reset ignores three edges with d = 1
        chain_d = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold_q%0d", k), {7'd0, q}, 8'h00);
            check($sformatf("reset_hold_chain%0d", k), {4'd0, stage}, 8'h00);
        end

        // Release mid-cycle; first edge afterwards captures
        @(negedge clk);
        rst = 1'b0;
        wd  = 8'h3C;
        #1;
        check("release_midcycle_q", {7'd0, q}, 8'h00);
        @(posedge clk);
        #1;
        check("post_release_q", {7'd0, q}, 8'h01);
        check("post_release_wide", wq, 8'h3C);
        check("post_release_chain", {4'd0, stage}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
